// File: rtl/nes_pkg.sv
// +--------------------------------------------------------------------+
// | nes_pkg: shared types and constants for the 6502 operand fetcher    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package nes_pkg;

  localparam int ADDR_W = 16;
  localparam logic [7:0] ZP_PAGE = 8'h00;

  typedef enum logic [3:0] {
    AM_IMM  = 4'd0,
    AM_ZP   = 4'd1,
    AM_ZPX  = 4'd2,
    AM_ZPY  = 4'd3,
    AM_ABS  = 4'd4,
    AM_ABSX = 4'd5,
    AM_ABSY = 4'd6,
    AM_INDX = 4'd7,
    AM_INDY = 4'd8,
    AM_IMP  = 4'd9
  } addr_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PTR_LO  = 3'd1,
    ST_PTR_HI  = 3'd2,
    ST_PENALTY = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5
  } opfetch_state_t;

endpackage

`default_nettype wire

// File: rtl/operand_fetch_if.sv
// +--------------------------------------------------------------------+
// | operand_fetch_if: request, memory-read and result signals          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface operand_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              start;
  logic [3:0]        mode;
  logic [DATA_W-1:0] op_lo;
  logic [DATA_W-1:0] op_hi;
  logic [DATA_W-1:0] index_x;
  logic [DATA_W-1:0] index_y;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] operand;
  logic [ADDR_W-1:0] eff_addr;
  logic              page_cross;

  // CPU core and memory side together
  modport master (
    output start, mode, op_lo, op_hi, index_x, index_y, mem_ack, mem_rdata,
    input  mem_req, mem_addr, busy, done, operand, eff_addr, page_cross
  );

  modport slave (
    input  start, mode, op_lo, op_hi, index_x, index_y, mem_ack, mem_rdata,
    output mem_req, mem_addr, busy, done, operand, eff_addr, page_cross
  );
endinterface

`default_nettype wire

// File: rtl/opfetch_agu.sv
// +--------------------------------------------------------------------+
// | opfetch_agu: index add with zero-page or 16-bit wrap, page carry   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module opfetch_agu
  import nes_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  wire logic [DATA_W-1:0]   i_base_lo,
  input  wire logic [DATA_W-1:0]   i_base_hi,
  input  wire logic [DATA_W-1:0]   i_index,
  input  wire logic                i_zp,
  output logic      [2*DATA_W-1:0] o_addr,
  output logic                     o_carry
);

  logic [DATA_W:0]   w_lo_sum;
  logic [DATA_W-1:0] w_hi_sum;

  assign w_lo_sum = {1'b0, i_base_lo} + {1'b0, i_index};
  assign w_hi_sum = i_base_hi + {{(DATA_W-1){1'b0}}, w_lo_sum[DATA_W]};

  // Zero-page modes discard the carry and stay in page 0
  assign o_addr  = i_zp ? {ZP_PAGE, w_lo_sum[DATA_W-1:0]}
                        : {w_hi_sum, w_lo_sum[DATA_W-1:0]};
  assign o_carry = w_lo_sum[DATA_W];

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// +--------------------------------------------------------------------+
// | operand_fetch: 6502 addressing-mode resolver (FSM + registers).     |
// | OPFETCH_PAGE_PENALTY_EN adds one cycle on page-crossing reads.      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module operand_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input wire logic          clk,
  input wire logic          reset,
  operand_fetch_if.slave    bus
);
  import nes_pkg::*;

  opfetch_state_t    r_state;
  logic              r_busy;
  logic [3:0]        r_mode;
  logic [DATA_W-1:0] r_op_lo;
  logic [DATA_W-1:0] r_op_hi;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic [DATA_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_ptr_lo;
  logic [DATA_W-1:0] r_operand;
  logic [ADDR_W-1:0] r_eff_addr;
  logic              r_page_cross;

  logic [DATA_W-1:0] w_base_lo;
  logic [DATA_W-1:0] w_base_hi;
  logic [DATA_W-1:0] w_index;
  logic              w_zp;
  logic [ADDR_W-1:0] w_agu_addr;
  logic              w_agu_carry;
  logic [DATA_W-1:0] w_ptr_next;
  opfetch_state_t    w_read_next;

  // The low pointer byte is in r_ptr_lo; the high one arrives on mem_rdata
  always_comb begin
    w_base_lo = r_op_lo;
    w_base_hi = r_op_hi;
    w_index   = '0;
    w_zp      = 1'b0;
    if (r_state == ST_PTR_HI) begin
      w_base_lo = r_ptr_lo;
      w_base_hi = bus.mem_rdata;
      w_index   = (r_mode == AM_INDY) ? r_y : '0;
    end else begin
      case (r_mode)
        AM_ZP:   w_zp = 1'b1;
        AM_ZPX:  begin w_zp = 1'b1; w_index = r_x; end
        AM_ZPY:  begin w_zp = 1'b1; w_index = r_y; end
        AM_ABSX: w_index = r_x;
        AM_ABSY: w_index = r_y;
        AM_INDX: begin w_zp = 1'b1; w_index = r_x; end
        AM_INDY: w_zp = 1'b1;
        default: ;
      endcase
    end
  end

  opfetch_agu #(
    .DATA_W (DATA_W)
  ) u_agu (
    .i_base_lo (w_base_lo),
    .i_base_hi (w_base_hi),
    .i_index   (w_index),
    .i_zp      (w_zp),
    .o_addr    (w_agu_addr),
    .o_carry   (w_agu_carry)
  );

  assign w_ptr_next = r_ptr + DATA_W'(1);

`ifdef OPFETCH_PAGE_PENALTY_EN
  assign w_read_next = w_agu_carry ? ST_PENALTY : ST_READ;
`else
  assign w_read_next = ST_READ;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_mode       <= '0;
      r_op_lo      <= '0;
      r_op_hi      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_ptr        <= '0;
      r_ptr_lo     <= '0;
      r_operand    <= '0;
      r_eff_addr   <= '0;
      r_page_cross <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_busy) begin
            if (bus.start) begin
              r_busy       <= 1'b1;
              r_mode       <= bus.mode;
              r_op_lo      <= bus.op_lo;
              r_op_hi      <= bus.op_hi;
              r_x          <= bus.index_x;
              r_y          <= bus.index_y;
              r_operand    <= '0;
              r_eff_addr   <= '0;
              r_page_cross <= 1'b0;
            end
          end else begin
            // Decode cycle: latched operands are stable here
            case (r_mode)
              AM_IMM: begin
                r_operand <= r_op_lo;
                r_state   <= ST_DONE;
              end
              AM_ZP, AM_ZPX, AM_ZPY, AM_ABS: begin
                r_eff_addr <= w_agu_addr;
                r_state    <= ST_READ;
              end
              AM_ABSX, AM_ABSY: begin
                r_eff_addr   <= w_agu_addr;
                r_page_cross <= w_agu_carry;
                r_state      <= w_read_next;
              end
              AM_INDX, AM_INDY: begin
                r_ptr   <= w_agu_addr[DATA_W-1:0];
                r_state <= ST_PTR_LO;
              end
              default: r_state <= ST_DONE;
            endcase
          end
        end
        ST_PTR_LO: begin
          if (bus.mem_ack) begin
            r_ptr_lo <= bus.mem_rdata;
            r_state  <= ST_PTR_HI;
          end
        end
        ST_PTR_HI: begin
          if (bus.mem_ack) begin
            r_eff_addr   <= w_agu_addr;
            r_page_cross <= (r_mode == AM_INDY) && w_agu_carry;
            r_state      <= w_read_next;
          end
        end
        ST_PENALTY: r_state <= ST_READ;
        ST_READ: begin
          if (bus.mem_ack) begin
            r_operand <= bus.mem_rdata;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr = '0;
    case (r_state)
      ST_PTR_LO: bus.mem_addr = {ZP_PAGE, r_ptr};
      ST_PTR_HI: bus.mem_addr = {ZP_PAGE, w_ptr_next};
      ST_READ:   bus.mem_addr = r_eff_addr;
      default:   bus.mem_addr = '0;
    endcase
  end

  assign bus.mem_req    = (r_state == ST_PTR_LO) || (r_state == ST_PTR_HI) ||
                          (r_state == ST_READ);
  assign bus.busy       = r_busy;
  assign bus.done       = (r_state == ST_DONE);
  assign bus.operand    = r_operand;
  assign bus.eff_addr   = r_eff_addr;
  assign bus.page_cross = r_page_cross;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// +--------------------------------------------------------------------+
// | tb_operand_fetch: directed tests for operand_fetch                  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_operand_fetch;

`ifdef OPFETCH_PAGE_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          ack_delay  = 0;
  logic        manual_ack = 1'b0;
  int          wait_cnt   = 0;
  logic [15:0] rd_log[$];

  operand_fetch_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  operand_fetch #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h0010: return 8'h77;
      16'h00FF: return 8'h34;
      16'h0000: return 8'h12;
      16'h1234: return 8'h9C;
      16'h1300: return 8'hA5;
      16'h0040: return 8'hF0;
      16'h0041: return 8'h12;
      16'h1310: return 8'h5E;
      default:  return a[7:0] ^ a[15:8];
    endcase
  endfunction

  // Memory model: acks after ack_delay waiting cycles, logs acked addresses
  initial begin
    forever begin
      @(negedge clk);
      if (!manual_ack) begin
        if (bus.mem_req === 1'b1 && !reset) begin
          if (wait_cnt >= ack_delay) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_rd(bus.mem_addr);
            rd_log.push_back(bus.mem_addr);
            wait_cnt = 0;
          end else begin
            bus.mem_ack = 1'b0;
            wait_cnt++;
          end
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt    = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Returns cycles from start to done and the first cycle mem_req was seen
  task automatic run_op(input logic [3:0] m, input logic [7:0] lo, hi, x, y,
                        output int lat, output int first_req);
    @(negedge clk);
    bus.mode = m; bus.op_lo = lo; bus.op_hi = hi;
    bus.index_x = x; bus.index_y = y; bus.start = 1'b1;
    rd_log.delete();
    first_req = -1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.mem_req === 1'b1 && first_req < 0) first_req = lat;
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: mode %0d got no done in %0d cycles", m, lat);
    end
  endtask

  task automatic test_reset();
    n_tests += 7;
    if (bus.mem_req !== 1'b0)      begin n_fail++; $display("FAIL rst_mem_req: got %b exp 0", bus.mem_req); end
    if (bus.busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
    if (bus.done !== 1'b0)         begin n_fail++; $display("FAIL rst_done: got %b exp 0", bus.done); end
    if (bus.operand !== 8'h00)     begin n_fail++; $display("FAIL rst_operand: got %h exp 00", bus.operand); end
    if (bus.eff_addr !== 16'h0)    begin n_fail++; $display("FAIL rst_eff_addr: got %h exp 0000", bus.eff_addr); end
    if (bus.page_cross !== 1'b0)   begin n_fail++; $display("FAIL rst_page_cross: got %b exp 0", bus.page_cross); end
    if (bus.mem_addr !== 16'h0)    begin n_fail++; $display("FAIL rst_mem_addr: got %h exp 0000", bus.mem_addr); end
  endtask

  task automatic test_imm();
    int lat, fr;
    run_op(4'd0, 8'h5A, 8'h00, 8'h00, 8'h00, lat, fr);
    n_tests += 5;
    if (lat !== 2)              begin n_fail++; $display("FAIL imm_latency: got %0d exp 2", lat); end
    if (bus.operand !== 8'h5A)  begin n_fail++; $display("FAIL imm_operand: got %h exp 5a", bus.operand); end
    if (bus.eff_addr !== 16'h0) begin n_fail++; $display("FAIL imm_eff_addr: got %h exp 0000", bus.eff_addr); end
    if (fr !== -1)              begin n_fail++; $display("FAIL imm_no_mem: mem_req seen at cycle %0d exp none", fr); end
    @(negedge clk);
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL imm_done_pulse: done %b busy %b exp 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_imp_illegal();
    int lat, fr;
    run_op(4'd9, 8'h33, 8'h44, 8'h00, 8'h00, lat, fr);
    n_tests += 2;
    if (bus.operand !== 8'h00 || fr !== -1)
      begin n_fail++; $display("FAIL imp_operand: got %h req %0d exp 00 -1", bus.operand, fr); end
    if (lat !== 2) begin n_fail++; $display("FAIL imp_latency: got %0d exp 2", lat); end
    run_op(4'd12, 8'h33, 8'h44, 8'h01, 8'h01, lat, fr);
    n_tests += 2;
    if (bus.operand !== 8'h00 || bus.eff_addr !== 16'h0)
      begin n_fail++; $display("FAIL illegal_result: got %h/%h exp 00/0000", bus.operand, bus.eff_addr); end
    if (fr !== -1 || lat !== 2)
      begin n_fail++; $display("FAIL illegal_timing: req %0d lat %0d exp -1 2", fr, lat); end
  endtask

  task automatic test_zpx();
    int lat, fr;
    run_op(4'd2, 8'hF0, 8'h99, 8'h20, 8'h00, lat, fr);
    n_tests += 4;
    if (bus.operand !== 8'h77)     begin n_fail++; $display("FAIL zpx_operand: got %h exp 77", bus.operand); end
    if (bus.eff_addr !== 16'h0010) begin n_fail++; $display("FAIL zpx_eff_addr: got %h exp 0010", bus.eff_addr); end
    if (rd_log.size() != 1 || rd_log[0] !== 16'h0010)
      begin n_fail++; $display("FAIL zpx_mem_addr: %0d reads first %h exp 1 read at 0010", rd_log.size(), rd_log.size() > 0 ? rd_log[0] : 16'hxxxx); end
    if (lat !== 3 || bus.page_cross !== 1'b0)
      begin n_fail++; $display("FAIL zpx_timing: lat %0d pc %b exp 3 0", lat, bus.page_cross); end
  endtask

  task automatic test_zp_wait();
    int lat, fr;
    ack_delay = 2;
    run_op(4'd1, 8'h10, 8'h00, 8'h00, 8'h00, lat, fr);
    ack_delay = 0;
    n_tests += 2;
    if (bus.operand !== 8'h77) begin n_fail++; $display("FAIL zp_wait_operand: got %h exp 77", bus.operand); end
    if (lat !== 5)             begin n_fail++; $display("FAIL zp_wait_latency: got %0d exp 5", lat); end
  endtask

  task automatic test_indx();
    int lat, fr;
    run_op(4'd7, 8'hFE, 8'h00, 8'h01, 8'h00, lat, fr);
    n_tests += 4;
    if (rd_log.size() != 3 || rd_log[0] !== 16'h00FF || rd_log[1] !== 16'h0000 || rd_log[2] !== 16'h1234)
      begin n_fail++; $display("FAIL indx_reads: %0d reads, exp 00ff 0000 1234", rd_log.size()); end
    if (bus.operand !== 8'h9C)     begin n_fail++; $display("FAIL indx_operand: got %h exp 9c", bus.operand); end
    if (bus.eff_addr !== 16'h1234) begin n_fail++; $display("FAIL indx_eff_addr: got %h exp 1234", bus.eff_addr); end
    if (lat !== 5 || bus.page_cross !== 1'b0)
      begin n_fail++; $display("FAIL indx_timing: lat %0d pc %b exp 5 0", lat, bus.page_cross); end
  endtask

  task automatic test_indy();
    int lat, fr;
    run_op(4'd8, 8'h40, 8'h00, 8'h00, 8'h20, lat, fr);
    n_tests += 3;
    if (bus.eff_addr !== 16'h1310 || bus.page_cross !== 1'b1)
      begin n_fail++; $display("FAIL indy_addr: got %h pc %b exp 1310 1", bus.eff_addr, bus.page_cross); end
    if (bus.operand !== 8'h5E) begin n_fail++; $display("FAIL indy_operand: got %h exp 5e", bus.operand); end
    if (lat !== 5 + PEN)       begin n_fail++; $display("FAIL indy_latency: got %0d exp %0d", lat, 5 + PEN); end
  endtask

  task automatic test_abs_page();
    int lat, fr;
    run_op(4'd6, 8'hFF, 8'h12, 8'h00, 8'h01, lat, fr);
    n_tests += 3;
    if (bus.eff_addr !== 16'h1300 || bus.page_cross !== 1'b1)
      begin n_fail++; $display("FAIL absy_addr: got %h pc %b exp 1300 1", bus.eff_addr, bus.page_cross); end
    if (bus.operand !== 8'hA5) begin n_fail++; $display("FAIL absy_operand: got %h exp a5", bus.operand); end
    if (fr !== 2 + PEN || lat !== 3 + PEN)
      begin n_fail++; $display("FAIL absy_timing: read at %0d done at %0d exp %0d %0d", fr, lat, 2 + PEN, 3 + PEN); end
    run_op(4'd5, 8'h34, 8'h12, 8'h05, 8'h00, lat, fr);
    n_tests += 2;
    if (bus.eff_addr !== 16'h1239 || bus.page_cross !== 1'b0 || bus.operand !== 8'h2B)
      begin n_fail++; $display("FAIL absx_result: got %h pc %b op %h exp 1239 0 2b", bus.eff_addr, bus.page_cross, bus.operand); end
    if (lat !== 3) begin n_fail++; $display("FAIL absx_latency: got %0d exp 3", lat); end
    run_op(4'd4, 8'hFF, 8'hFF, 8'h00, 8'h00, lat, fr);
    n_tests++;
    if (bus.eff_addr !== 16'hFFFF || bus.page_cross !== 1'b0 || bus.operand !== 8'h00)
      begin n_fail++; $display("FAIL abs_top: got %h pc %b op %h exp ffff 0 00", bus.eff_addr, bus.page_cross, bus.operand); end
  endtask

  task automatic test_start_in_done();
    int   lat, fr;
    logic seen;
    run_op(4'd0, 8'h5A, 8'h00, 8'h00, 8'h00, lat, fr);
    bus.mode = 4'd0; bus.op_lo = 8'h11; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_tests += 2;
    if (seen !== 1'b0)         begin n_fail++; $display("FAIL done_start_ignored: busy/done seen %b exp 0", seen); end
    if (bus.operand !== 8'h5A) begin n_fail++; $display("FAIL done_hold_operand: got %h exp 5a", bus.operand); end
  endtask

  task automatic test_reset_mid();
    int   lat, fr;
    logic seen;
    manual_ack = 1'b1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    bus.mode = 4'd4; bus.op_lo = 8'h00; bus.op_hi = 8'h20; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h2000)
      begin n_fail++; $display("FAIL rmid_req: got %b/%h exp 1/2000", bus.mem_req, bus.mem_addr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 16'h0)
      begin n_fail++; $display("FAIL rmid_abandon: req %b busy %b addr %h exp 0 0 0000", bus.mem_req, bus.busy, bus.mem_addr); end
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0) seen = 1'b1;
    end
    n_tests += 2;
    if (seen !== 1'b0)         begin n_fail++; $display("FAIL rmid_late_ack: activity seen %b exp 0", seen); end
    if (bus.operand !== 8'h00) begin n_fail++; $display("FAIL rmid_operand: got %h exp 00", bus.operand); end
    manual_ack = 1'b0;
    run_op(4'd2, 8'hF0, 8'h00, 8'h20, 8'h00, lat, fr);
    n_tests++;
    if (bus.operand !== 8'h77 || lat !== 3)
      begin n_fail++; $display("FAIL rmid_recover: op %h lat %0d exp 77 3", bus.operand, lat); end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 4'd0; bus.op_lo = 8'h00; bus.op_hi = 8'h00;
    bus.index_x = 8'h00; bus.index_y = 8'h00;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_imm();
    test_imp_illegal();
    test_zpx();
    test_zp_wait();
    test_indx();
    test_indy();
    test_abs_page();
    test_start_in_done();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, CPU address width.
REQ-002 Parameter DATA_W, default 8, data and register width.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to resolve one operand; ignored while busy=1.
REQ-006 mode  input  4  addressing mode code: IMM=0, ZP=1, ZPX=2, ZPY=3, ABS=4, ABSX=5, ABSY=6, INDX=7, INDY=8, IMP=9; codes 10-15 are illegal.
REQ-007 op_lo, op_hi  input  8 each  instruction operand bytes, sampled at start.
REQ-008 index_x, index_y  input  8 each  X and Y registers, sampled at start.
REQ-009 mem_req  output  1  memory read request.
REQ-010 mem_addr  output  16  read address, valid while mem_req=1.
REQ-011 mem_ack  input  1  read complete; mem_rdata is valid in the same cycle.
REQ-012 mem_rdata  input  8  read data.
REQ-013 busy  output  1  high from the cycle after start until done.
REQ-014 done  output  1  one-cycle pulse; operand and eff_addr are valid.
REQ-015 operand  output  8  resolved value for the ALU second operand.
REQ-016 eff_addr  output  16  effective address, reused for store and read-modify-write.
REQ-017 page_cross  output  1  high with done when indexing carried out of the low address byte.

Function
REQ-018 The FSM SHALL have states IDLE, PTR_LO, PTR_HI, PENALTY, READ and DONE; all transitions occur only on clk.
REQ-019 In IDLE, start SHALL latch mode, op_lo, op_hi, index_x and index_y, and set busy in the next cycle.
REQ-020 IMM SHALL go IDLE->DONE, with operand=op_lo, eff_addr=0 and no memory access; done is asserted 2 cycles after start.
REQ-021 IMP and illegal codes SHALL go IDLE->DONE, with operand=0, eff_addr=0 and no memory access.
REQ-022 ZP/ZPX/ZPY SHALL use eff_addr = {8'h00, (op_lo + index) mod 256}, then READ.
REQ-023 ABS/ABSX/ABSY SHALL use eff_addr = {op_hi,op_lo} + zero-extended index, 16-bit, wrapping at FFFF, then READ.
REQ-024 INDX SHALL compute ptr = (op_lo + X) mod 256, read the low byte at {00,ptr} (PTR_LO), read the high byte at {00,(ptr+1) mod 256} (PTR_HI), then READ at {hi,lo}.
REQ-025 INDY SHALL compute ptr = op_lo, fetch lo/hi as in INDX, then READ at {hi,lo}+Y with 16-bit wrap.
REQ-026 page_cross SHALL be 1 only for ABSX, ABSY and INDY when the low-byte add carries out; otherwise 0.
REQ-027 mem_req and mem_addr SHALL be held stable each cycle until mem_ack=1; data is captured in the ack cycle, and the next access or DONE follows in the next cycle.
REQ-028 A same-cycle ack (mem_ack=1 in the first request cycle) SHALL be legal; the wait length SHALL be unbounded.
REQ-029 In DONE, done=1 for exactly one cycle, then the FSM returns to IDLE; operand, eff_addr and page_cross SHALL hold until the next accepted start.
REQ-030 A start asserted in the DONE cycle SHALL be ignored.
REQ-031 mem_req SHALL be 0 in IDLE and DONE.

Reset
REQ-032 While reset=1, the block SHALL enter IDLE, with mem_req=0, busy=0, done=0, operand=0, eff_addr=0, page_cross=0 and mem_addr=0.
REQ-033 Reset mid-access SHALL abandon the transaction without a done pulse; an ack arriving during or after reset SHALL be ignored.

Configuration
REQ-034 Macro OPFETCH_PAGE_PENALTY_EN: when defined, a page_cross=1 access SHALL pass through PENALTY for one extra cycle before READ, matching 6502 timing.
REQ-035 When the macro is not defined, the PENALTY state SHALL be unreachable; page_cross SHALL still be reported, and timing is independent of page crossing.

Structure
REQ-036 Package nes_pkg SHALL hold the addr_mode_t enum (the codes in REQ-006), the opfetch_state_t enum, and the constants ZP_PAGE=8'h00 and ADDR_W.
REQ-037 Sub-module opfetch_agu SHALL contain the combinational index-add, wrap and page-cross logic; operand_fetch holds the FSM and registers.

Verification
REQ-038 IMM, op_lo=8'h5A -> done 2 cycles after start, operand=5A, mem_req never high.
REQ-039 ZPX, op_lo=F0, X=20, mem[0010]=77 -> mem_addr=0010 (wrap), operand=77, eff_addr=0010.
REQ-040 INDX, op_lo=FE, X=01, mem[00FF]=34, mem[0000]=12, mem[1234]=9C -> reads at 00FF, 0000, then 1234; operand=9C.
REQ-041 ABSY, op_hi:lo=12FF, Y=01 -> eff_addr=1300, page_cross=1; READ starts 1 cycle later with the macro defined than without it.
REQ-042 ABS read with mem_ack delayed 3 cycles, reset pulsed on cycle 2 -> mem_req=0 next cycle, no done, late ack ignored; the next start completes normally.
